// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU result checker:
//     - ALU opcode encodings (OP_MOV .. OP_SLT, OP_RSVD)
//     - checker state encodings (ST_IDLE, ST_RUN, ST_FAILED)
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FAILED = 2'b10
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// ----------------------------------------------------------------------------
// alu_ref_model
//   Combinational golden model of the ALU. Produces the expected N-bit result
//   for an issued op; overflow bits are simply dropped.
// Ports
//   op       in   3   ALU opcode
//   a        in   N   first operand (R2)
//   b        in   N   second operand (R3)
//   expected out  N   expected low N bits of the result
//   chk_en   out  1   0 for the reserved opcode, which is never checked
// ----------------------------------------------------------------------------
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] expected,
  output logic         chk_en
);

  always_comb begin
    expected = '0;
    chk_en   = 1'b1;
    case (op)
      OP_MOV: expected = a;
      OP_NOT: expected = ~a;
      OP_ADD: expected = a + b;
      OP_SUB: expected = a - b;
      OP_OR:  expected = a | b;
      OP_AND: expected = a & b;
      OP_SLT: expected = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        expected = '0;
        chk_en   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// ----------------------------------------------------------------------------
// alu_result_checker
//   Taps ops issued to an N-bit registered ALU, computes the expected result
//   at issue, delays it LAT cycles to line up with the ALU's registered output
//   and compares. Counts comparisons and mismatches (saturating) and tracks a
//   sticky pass/fail state for self-test and bring-up.
//
//   Optional feature macro: ALU_CHK_CAPTURE_EN
//     When defined, the operands travel down the delay line with the expected
//     value and fail_a/fail_b/fail_expected/fail_actual are latched together
//     with first_fail_op.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   clear          in   1   synchronous clear of counters, state, pipeline
//   in_valid       in   1   op issued to the ALU this cycle
//   in_op          in   3   opcode issued
//   in_a, in_b     in   N   operands issued
//   dut_result     in   N   ALU registered result
//   chk_valid      out  1   a comparison happened (registered)
//   err_flag       out  1   that comparison mismatched (registered)
//   checked_count  out  CW  comparisons performed, saturating
//   error_count    out  CW  mismatches, saturating
//   state          out  2   00 IDLE, 01 RUN, 10 FAILED
//   first_fail_op  out  3   opcode of the first mismatch
//   fail_a/fail_b/fail_expected/fail_actual  out N  (ALU_CHK_CAPTURE_EN only)
// ----------------------------------------------------------------------------
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int N   = 32,
  parameter int LAT = 1,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [2:0]    in_op,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [N-1:0]  dut_result,
  output logic          chk_valid,
  output logic          err_flag,
  output logic [CW-1:0] checked_count,
  output logic [CW-1:0] error_count,
  output logic [1:0]    state,
`ifdef ALU_CHK_CAPTURE_EN
  output logic [N-1:0]  fail_a,
  output logic [N-1:0]  fail_b,
  output logic [N-1:0]  fail_expected,
  output logic [N-1:0]  fail_actual,
`endif
  output logic [2:0]    first_fail_op
);

  logic [N-1:0] ref_expected;
  logic         ref_chk_en;

  alu_ref_model #(.N(N)) u_ref (
    .op       (in_op),
    .a        (in_a),
    .b        (in_b),
    .expected (ref_expected),
    .chk_en   (ref_chk_en)
  );

  // Delay line: stage 0 is loaded at issue, stage LAT-1 lines up with dut_result.
  logic [LAT-1:0]        vld_q, vld_d;
  logic [LAT-1:0][2:0]   op_q,  op_d;
  logic [LAT-1:0][N-1:0] exp_q, exp_d;
`ifdef ALU_CHK_CAPTURE_EN
  logic [LAT-1:0][N-1:0] a_q, a_d;
  logic [LAT-1:0][N-1:0] b_q, b_d;
`endif

  logic          chk_valid_q, chk_valid_d;
  logic          err_flag_q,  err_flag_d;
  logic [CW-1:0] checked_q,   checked_d;
  logic [CW-1:0] errors_q,    errors_d;
  chk_state_e    state_q,     state_d;
  logic [2:0]    ffop_q,      ffop_d;
`ifdef ALU_CHK_CAPTURE_EN
  logic [N-1:0]  fa_q, fa_d;
  logic [N-1:0]  fb_q, fb_d;
  logic [N-1:0]  fe_q, fe_d;
  logic [N-1:0]  fr_q, fr_d;
`endif

  logic cmp_valid;
  logic mismatch;
  logic first_fail;

  assign cmp_valid  = vld_q[LAT-1];
  assign mismatch   = (dut_result != exp_q[LAT-1]);
  // Latch diagnostics only on the transition into FAILED.
  assign first_fail = cmp_valid && mismatch && (state_q != ST_FAILED);

  always_comb begin
    vld_d = '0;
    op_d  = op_q;
    exp_d = exp_q;
`ifdef ALU_CHK_CAPTURE_EN
    a_d   = a_q;
    b_d   = b_q;
`endif
    // The reserved opcode enters with valid=0, so it is never compared.
    vld_d[0] = in_valid & ref_chk_en & ~clear;
    op_d[0]  = in_op;
    exp_d[0] = ref_expected;
`ifdef ALU_CHK_CAPTURE_EN
    a_d[0]   = in_a;
    b_d[0]   = in_b;
`endif
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1] & ~clear;
      op_d[i]  = op_q[i-1];
      exp_d[i] = exp_q[i-1];
`ifdef ALU_CHK_CAPTURE_EN
      a_d[i]   = a_q[i-1];
      b_d[i]   = b_q[i-1];
`endif
    end
  end

  always_comb begin
    chk_valid_d = 1'b0;
    err_flag_d  = 1'b0;
    checked_d   = checked_q;
    errors_d    = errors_q;
    state_d     = state_q;
    ffop_d      = ffop_q;
`ifdef ALU_CHK_CAPTURE_EN
    fa_d        = fa_q;
    fb_d        = fb_q;
    fe_d        = fe_q;
    fr_d        = fr_q;
`endif
    if (clear) begin
      // A compare coinciding with clear is dropped without being counted.
      checked_d = '0;
      errors_d  = '0;
      state_d   = ST_IDLE;
      ffop_d    = '0;
`ifdef ALU_CHK_CAPTURE_EN
      fa_d      = '0;
      fb_d      = '0;
      fe_d      = '0;
      fr_d      = '0;
`endif
    end else if (cmp_valid) begin
      chk_valid_d = 1'b1;
      err_flag_d  = mismatch;
      if (checked_q != {CW{1'b1}}) checked_d = checked_q + CW'(1);
      if (mismatch && (errors_q != {CW{1'b1}})) errors_d = errors_q + CW'(1);
      case (state_q)
        ST_IDLE:   state_d = mismatch ? ST_FAILED : ST_RUN;
        ST_RUN:    state_d = mismatch ? ST_FAILED : ST_RUN;
        default:   state_d = ST_FAILED;
      endcase
      if (first_fail) begin
        ffop_d = op_q[LAT-1];
`ifdef ALU_CHK_CAPTURE_EN
        fa_d   = a_q[LAT-1];
        fb_d   = b_q[LAT-1];
        fe_d   = exp_q[LAT-1];
        fr_d   = dut_result;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      op_q        <= '0;
      exp_q       <= '0;
      chk_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      checked_q   <= '0;
      errors_q    <= '0;
      state_q     <= ST_IDLE;
      ffop_q      <= '0;
`ifdef ALU_CHK_CAPTURE_EN
      a_q         <= '0;
      b_q         <= '0;
      fa_q        <= '0;
      fb_q        <= '0;
      fe_q        <= '0;
      fr_q        <= '0;
`endif
    end else begin
      vld_q       <= vld_d;
      op_q        <= op_d;
      exp_q       <= exp_d;
      chk_valid_q <= chk_valid_d;
      err_flag_q  <= err_flag_d;
      checked_q   <= checked_d;
      errors_q    <= errors_d;
      state_q     <= state_d;
      ffop_q      <= ffop_d;
`ifdef ALU_CHK_CAPTURE_EN
      a_q         <= a_d;
      b_q         <= b_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      fe_q        <= fe_d;
      fr_q        <= fr_d;
`endif
    end
  end

  assign chk_valid     = chk_valid_q;
  assign err_flag      = err_flag_q;
  assign checked_count = checked_q;
  assign error_count   = errors_q;
  assign state         = state_q;
  assign first_fail_op = ffop_q;
`ifdef ALU_CHK_CAPTURE_EN
  assign fail_a        = fa_q;
  assign fail_b        = fb_q;
  assign fail_expected = fe_q;
  assign fail_actual   = fr_q;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// ----------------------------------------------------------------------------
// tb_alu_result_checker
//   Drives a behavioural registered ALU into two checker instances (CW=16 and
//   CW=4). A scoreboard records each checked issue with its issue cycle and
//   whether the ALU output was corrupted; a negedge monitor pops it when
//   chk_valid appears and checks err_flag and the issue-to-flag latency.
// ----------------------------------------------------------------------------
module tb_alu_result_checker;

  localparam int N   = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [2:0]    in_op;
  logic [N-1:0]  in_a, in_b;
  logic [N-1:0]  dut_result;

  logic          chk_valid, err_flag;
  logic [15:0]   checked_count, error_count;
  logic [1:0]    state;
  logic [2:0]    first_fail_op;

  logic          chk_valid4, err_flag4;
  logic [3:0]    checked_count4, error_count4;
  logic [1:0]    state4;
  logic [2:0]    first_fail_op4;
`ifdef ALU_CHK_CAPTURE_EN
  logic [N-1:0]  fail_a, fail_b, fail_expected, fail_actual;
  logic [N-1:0]  fail_a4, fail_b4, fail_expected4, fail_actual4;
`endif

  always #5 clk = ~clk;

  alu_result_checker #(.N(N), .LAT(LAT), .CW(16)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .dut_result    (dut_result),
    .chk_valid     (chk_valid),
    .err_flag      (err_flag),
    .checked_count (checked_count),
    .error_count   (error_count),
    .state         (state),
`ifdef ALU_CHK_CAPTURE_EN
    .fail_a        (fail_a),
    .fail_b        (fail_b),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual),
`endif
    .first_fail_op (first_fail_op)
  );

  alu_result_checker #(.N(N), .LAT(LAT), .CW(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .dut_result    (dut_result),
    .chk_valid     (chk_valid4),
    .err_flag      (err_flag4),
    .checked_count (checked_count4),
    .error_count   (error_count4),
    .state         (state4),
`ifdef ALU_CHK_CAPTURE_EN
    .fail_a        (fail_a4),
    .fail_b        (fail_b4),
    .fail_expected (fail_expected4),
    .fail_actual   (fail_actual4),
`endif
    .first_fail_op (first_fail_op4)
  );

  // Behavioural registered ALU with optional output corruption.
  function automatic logic [N-1:0] alu_f(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] wide;
    case (op)
      3'd0: alu_f = a;
      3'd1: alu_f = a ^ {N{1'b1}};
      3'd2: begin wide = {1'b0, a} + {1'b0, b}; alu_f = wide[N-1:0]; end
      3'd3: begin wide = {1'b0, a} + {1'b0, ~b} + 1; alu_f = wide[N-1:0]; end
      3'd4: alu_f = a | b;
      3'd5: alu_f = a & b;
      3'd6: alu_f = (a[N-1] != b[N-1]) ? N'(a[N-1]) : N'(a < b);
      default: alu_f = '0;
    endcase
  endfunction

  logic         fault_in = 1'b0;
  logic         fault_q  = 1'b0;
  logic [N-1:0] alu_q    = '0;
  always @(posedge clk) begin
    alu_q   <= alu_f(in_op, in_a, in_b);
    fault_q <= fault_in;
  end
  assign dut_result = fault_q ? '0 : alu_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         icyc;
    logic       err;
  } sb_t;
  sb_t sb[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every chk_valid must match the oldest pending issue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && chk_valid === 1'b1) begin
      check("pending_on_chk", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        sb_t e;
        e = sb.pop_front();
        check("err_flag", 64'(err_flag), 64'(e.err));
        check("latency", 64'(cyc - e.icyc), 64'(LAT + 1));
        $display("chk issue_cyc=%0d err_flag=%0b checked=%0d errors=%0d", e.icyc, err_flag, checked_count, error_count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input logic flt);
    sb_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    fault_in = flt;
    if (op != 3'd7) begin
      e.icyc = cyc;
      e.err  = flt;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    fault_in = 1'b0;
  endtask

  initial begin
    // 1: reset with random inputs
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'($urandom); in_op = 3'($urandom); in_a = $urandom; in_b = $urandom;
      clear = 1'($urandom);
    end
    check("rst_chk_valid", 64'(chk_valid), 64'd0);
    check("rst_err_flag",  64'(err_flag), 64'd0);
    check("rst_checked",   64'(checked_count), 64'd0);
    check("rst_errors",    64'(error_count), 64'd0);
    check("rst_state",     64'(state), 64'd0);
    check("rst_ffop",      64'(first_fail_op), 64'd0);
    in_valid = 1'b0; clear = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(2);

    // 2: all checked ops with overflow/sign corner operands
    issue(3'd0, 32'h1234_5678, 32'h0, 1'b0);
    issue(3'd1, 32'h0F0F_00FF, 32'h0, 1'b0);
    issue(3'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    issue(3'd3, 32'h0000_0002, 32'h0000_0003, 1'b0);
    issue(3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
    issue(3'd5, 32'hFFFF_0F0F, 32'h0FF0_FFFF, 1'b0);
    issue(3'd6, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    idle(3);
    check("t2_checked",  64'(checked_count), 64'd7);
    check("t2_errors",   64'(error_count), 64'd0);
    check("t2_state",    64'(state), 64'd1);
    check("t2_checked4", 64'(checked_count4), 64'd7);

    // 3: fault injection on ADD 2+3
    issue(3'd2, 32'h2, 32'h3, 1'b1);
    tick();
    check("t3_errors", 64'(error_count), 64'd1);
    check("t3_state",  64'(state), 64'd2);
    check("t3_ffop",   64'(first_fail_op), 64'd2);
`ifdef ALU_CHK_CAPTURE_EN
    check("t3_fail_a",   64'(fail_a), 64'h2);
    check("t3_fail_b",   64'(fail_b), 64'h3);
    check("t3_fail_exp", 64'(fail_expected), 64'h5);
    check("t3_fail_act", 64'(fail_actual), 64'h0);
`endif
    issue(3'd0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue(3'd6, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0);
    issue(3'd4, 32'h0000_00F0, 32'h0000_000F, 1'b1);
    idle(3);
    check("t3_state_sticky", 64'(state), 64'd2);
    check("t3_ffop_kept",    64'(first_fail_op), 64'd2);
    check("t3_errors2",      64'(error_count), 64'd2);
    check("t3_checked",      64'(checked_count), 64'd11);

    // 4: reserved opcode is never checked
    for (int i = 0; i < 5; i++) issue(3'd7, $urandom, $urandom, 1'b0);
    idle(3);
    check("t4_op7_checked", 64'(checked_count), 64'd11);

    // 5a: clear coincides with a pending compare and with a new issue
    issue(3'd0, 32'h5, 32'h0, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_op = 3'd2; in_a = 32'h1; in_b = 32'h1;
    sb.delete();
    tick();
    clear = 1'b0; in_valid = 1'b0;
    idle(3);
    check("t5_clr_checked", 64'(checked_count), 64'd0);
    check("t5_clr_errors",  64'(error_count), 64'd0);
    check("t5_clr_state",   64'(state), 64'd0);
    check("t5_clr_ffop",    64'(first_fail_op), 64'd0);
    check("t5_clr_checked4", 64'(checked_count4), 64'd0);

    // 5b: reset pulsed mid-stream
    issue(3'd2, 32'h10, 32'h20, 1'b0);
    issue(3'd3, 32'h10, 32'h20, 1'b0);
    issue(3'd5, 32'hFF, 32'h0F, 1'b0);
    issue(3'd4, 32'h1, 32'h2, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_rst_checked", 64'(checked_count), 64'd0);
    check("t5_rst_chk_valid", 64'(chk_valid), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    check("t5_rst_checked_after", 64'(checked_count), 64'd0);
    check("t5_rst_state_after",   64'(state), 64'd0);

    // 4/6: 20 back-to-back matching ops, CW=4 saturates at 15
    for (int i = 0; i < 20; i++) issue(3'($urandom_range(0, 6)), $urandom, $urandom, 1'b0);
    idle(3);
    check("t6_checked20",  64'(checked_count), 64'd20);
    check("t6_errors",     64'(error_count), 64'd0);
    check("t6_state",      64'(state), 64'd1);
    check("t6_checked_sat", 64'(checked_count4), 64'd15);
    check("t6_errors4",    64'(error_count4), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
